// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle for serial_bit_feeder.
// The slave modport is the feeder's view; the master modport is the word source and detector's view.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             X;
  logic             x_valid;
  logic             last_bit;
  logic [CW-1:0]    bit_idx;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, X, x_valid, last_bit, bit_idx, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, X, x_valid, last_bit, bit_idx, busy
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end: WIDTH-bit words in, MSB-first bits out on X for the sequence detector.
// Define SERIAL_FEEDER_PARITY_EN to append an even-parity bit after each word's LSB.
module serial_bit_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef SERIAL_FEEDER_PARITY_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
`ifdef SERIAL_FEEDER_PARITY_EN
  logic             par, par_n;
`endif

  logic          ready;
  logic          accept;
  logic          x_bit;
  logic          x_vld;
  logic          lb;
  logic [CW-1:0] idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= {WIDTH{IDLE_BIT}};
      cnt   <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt   <= cnt_n;
`ifdef SERIAL_FEEDER_PARITY_EN
      par   <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n   = cnt;
`ifdef SERIAL_FEEDER_PARITY_EN
    par_n   = par;
`endif
    ready   = 1'b0;
    x_bit   = IDLE_BIT;
    x_vld   = 1'b0;
    lb      = 1'b0;
    idx     = '0;

    case (state)
      IDLE: begin
        ready = 1'b1;
      end

      SHIFT: begin
        x_bit   = shreg[WIDTH-1];
        x_vld   = 1'b1;
        idx     = cnt;
        shreg_n = {shreg[WIDTH-2:0], IDLE_BIT};
        cnt_n   = cnt + CW'(1);
        if (cnt == LAST) begin
          cnt_n = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
          state_n = PARITY;
`else
          // LSB cycle doubles as the reload window for zero-gap streaming
          lb      = 1'b1;
          ready   = 1'b1;
          state_n = IDLE;
`endif
        end
      end

`ifdef SERIAL_FEEDER_PARITY_EN
      PARITY: begin
        x_bit   = par;
        x_vld   = 1'b1;
        lb      = 1'b1;
        ready   = 1'b1;
        state_n = IDLE;
      end
`endif

      default: begin
        state_n = IDLE;
      end
    endcase

    // A new word overrides the fall-back to IDLE chosen above
    accept = bus.in_valid && ready && !reset;
    if (accept) begin
      shreg_n = bus.in_data;
      cnt_n   = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
      par_n   = ^bus.in_data;
`endif
      state_n = SHIFT;
    end
  end

  assign bus.in_ready = ready && !reset;
  assign bus.X        = x_bit;
  assign bus.x_valid  = x_vld;
  assign bus.last_bit = lb;
  assign bus.bit_idx  = idx;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder at WIDTH=5; works with or without SERIAL_FEEDER_PARITY_EN.
module tb_serial_bit_feeder;
  localparam int WIDTH = 5;
`ifdef SERIAL_FEEDER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int PER = WIDTH + P;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  serial_bit_feeder_if #(.WIDTH(WIDTH)) bus ();

  serial_bit_feeder #(.WIDTH(WIDTH), .IDLE_BIT(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".X"},       32'(bus.X),       32'(1'b1));
    chk({tag, ".x_valid"}, 32'(bus.x_valid), 32'(1'b0));
    chk({tag, ".busy"},    32'(bus.busy),    32'(1'b0));
    chk({tag, ".last"},    32'(bus.last_bit), 32'(1'b0));
    chk({tag, ".idx"},     32'(bus.bit_idx), 32'd0);
  endtask

  // Entered in the first valid cycle of an already accepted word. Bit n-k is the k-th bit on X.
  // With second_en, in_valid stays high with junk data until cycle load_at, where the second word appears.
  task automatic run_stream(input string tag, input logic [15:0] bits, input logic [15:0] rdy,
                            input logic [15:0] lbm, input int n, input bit second_en,
                            input logic [WIDTH-1:0] second, input int load_at);
    for (int k = 1; k <= n; k++) begin
      int pos;
      pos = (k - 1) % PER;
      chk($sformatf("%s.X[%0d]", tag, k),     32'(bus.X),        32'(bits[n-k]));
      chk($sformatf("%s.xv[%0d]", tag, k),    32'(bus.x_valid),  32'(1'b1));
      chk($sformatf("%s.rdy[%0d]", tag, k),   32'(bus.in_ready), 32'(rdy[n-k]));
      chk($sformatf("%s.last[%0d]", tag, k),  32'(bus.last_bit), 32'(lbm[n-k]));
      chk($sformatf("%s.busy[%0d]", tag, k),  32'(bus.busy),     32'(1'b1));
      if (pos < WIDTH)
        chk($sformatf("%s.idx[%0d]", tag, k), 32'(bus.bit_idx),  32'(pos));
      if (second_en && k < load_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = k[0] ? 5'b11111 : 5'b00000;
      end else if (second_en && k == load_at) begin
        bus.in_valid = 1'b1;
        bus.in_data  = second;
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = 5'b00000;
      end
      tick();
    end
    chk_idle({tag, ".after"});
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (2) tick();
    chk_idle("rst");
    chk("rst.ready", 32'(bus.in_ready), 32'(1'b0));

    reset = 1'b0;
    #1;
    chk("rel.ready", 32'(bus.in_ready), 32'(1'b1));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("quiet%0d", i));
      chk($sformatf("quiet%0d.ready", i), 32'(bus.in_ready), 32'(1'b1));
    end

    // Single word 01101
    bus.in_data  = 5'b01101;
    bus.in_valid = 1'b1;
    tick();
`ifdef SERIAL_FEEDER_PARITY_EN
    run_stream("single", 16'b011011, 16'b000001, 16'b000001, 6, 1'b0, 5'b0, 0);
`else
    run_stream("single", 16'b01101, 16'b00001, 16'b00001, 5, 1'b0, 5'b0, 0);
`endif
    tick();
    chk_idle("single.hold");

    // Back-to-back 01101 then 10010, with junk on in_data while not ready
    bus.in_data  = 5'b01101;
    bus.in_valid = 1'b1;
    tick();
`ifdef SERIAL_FEEDER_PARITY_EN
    run_stream("b2b", 16'b011011100100, 16'b000001000001, 16'b000001000001, 12, 1'b1, 5'b10010, 6);
`else
    run_stream("b2b", 16'b0110110010, 16'b0000100001, 16'b0000100001, 10, 1'b1, 5'b10010, 5);
`endif

    // Reset in the middle of a word
    bus.in_data  = 5'b01101;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mid.idx0", 32'(bus.bit_idx), 32'd0);
    tick();
    tick();
    chk("mid.idx2", 32'(bus.bit_idx), 32'd2);
    chk("mid.X2",   32'(bus.X),       32'(1'b1));
    reset = 1'b1;
    #1;
    chk_idle("mid.rst");
    chk("mid.rst.ready", 32'(bus.in_ready), 32'(1'b0));
    #3;
    reset        = 1'b0;
    bus.in_data  = 5'b10010;
    bus.in_valid = 1'b1;
    tick();
`ifdef SERIAL_FEEDER_PARITY_EN
    run_stream("post", 16'b100100, 16'b000001, 16'b000001, 6, 1'b0, 5'b0, 0);
`else
    run_stream("post", 16'b10010, 16'b00001, 16'b00001, 5, 1'b0, 5'b0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
